// File: rtl/mc6800_pkg.sv
// mc6800_pkg: shared definitions for the 6800-style motherboard bus scheduler.
//   - sched_state_e : scheduler FSM states
//   - *_DEF         : default E-clock phase constants
//   - REQ_CPU/POLL  : requester indices into REQ/GNT/ACK
//   - phase_mod     : folds a phase constant into the 4-bit counter range
package mc6800_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StActive,
    StDone
  } sched_state_e;

  localparam int unsigned E_PERIOD_DEF     = 10;
  localparam int unsigned E_HIGH_START_DEF = 6;
  localparam int unsigned VMA_PHASE_DEF    = 2;
  localparam int unsigned ACK_PHASE_DEF    = 8;

  localparam int unsigned REQ_CPU  = 0;
  localparam int unsigned REQ_POLL = 1;

  function automatic logic [3:0] phase_mod(input int unsigned value, input int unsigned period);
    return 4'(value % period);
  endfunction

endpackage

// File: rtl/mc6800_eclk_gen.sv
// mc6800_eclk_gen: free-running E-period phase counter and registered E clock.
//   i_clk    : motherboard clock
//   i_rst_n  : synchronous active-low reset
//   o_phase  : phase counter, 0..E_PERIOD-1
//   o_e_clk  : E clock, high for phases E_HIGH_START..E_PERIOD-1
module mc6800_eclk_gen
  import mc6800_pkg::*;
#(
  parameter int unsigned E_PERIOD     = E_PERIOD_DEF,
  parameter int unsigned E_HIGH_START = E_HIGH_START_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [3:0] o_phase,
  output logic       o_e_clk
);

  localparam logic [3:0] LP_LAST   = phase_mod(E_PERIOD - 1, E_PERIOD);
  localparam logic [3:0] LP_E_HIGH = phase_mod(E_HIGH_START, E_PERIOD);

  logic [3:0] r_phase;
  logic       r_e_clk;
  logic [3:0] w_phase_next;

  always_comb begin
    w_phase_next = (r_phase == LP_LAST) ? 4'd0 : r_phase + 4'd1;
  end

  // E is decoded from the next phase so the register lines up with the counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= 4'd0;
      r_e_clk <= 1'b0;
    end else begin
      r_phase <= w_phase_next;
      r_e_clk <= (w_phase_next >= LP_E_HIGH);
    end
  end

  assign o_phase = r_phase;
  assign o_e_clk = r_e_clk;

endmodule

// File: rtl/mc6800_bus_scheduler.sv
// mc6800_bus_scheduler: shares the E-clocked motherboard peripheral bus between the CPU VPA
// path (REQ_CPU) and a background poller (REQ_POLL) with round-robin arbitration.
//   MB_CLK   : motherboard clock, rising edge
//   RESET    : synchronous active-low reset
//   REQ      : request levels, held until ACK or withdrawn
//   GNT      : one-hot grant, zero when idle
//   ACK      : one-cycle completion pulse to the granted requester
//   MB_E_CLK : registered E clock
//   MB_VMA   : registered valid memory address, active-low
//   BUSY     : scheduler not idle
//   PHASE    : current E-period phase
// Legal parameters: 1 <= VMA_PHASE < E_HIGH_START <= ACK_PHASE < E_PERIOD-1, E_PERIOD <= 16.
module mc6800_bus_scheduler
  import mc6800_pkg::*;
#(
  parameter int unsigned E_PERIOD     = E_PERIOD_DEF,
  parameter int unsigned E_HIGH_START = E_HIGH_START_DEF,
  parameter int unsigned VMA_PHASE    = VMA_PHASE_DEF,
  parameter int unsigned ACK_PHASE    = ACK_PHASE_DEF
) (
  input  logic       MB_CLK,
  input  logic       RESET,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  output logic [1:0] ACK,
  output logic       MB_E_CLK,
  output logic       MB_VMA,
  output logic       BUSY,
  output logic [3:0] PHASE
);

  localparam logic [3:0] LP_VMA_ARM = phase_mod(VMA_PHASE + E_PERIOD - 1, E_PERIOD);
  localparam logic [3:0] LP_ACK     = phase_mod(ACK_PHASE, E_PERIOD);
  localparam logic [3:0] LP_LAST    = phase_mod(E_PERIOD - 1, E_PERIOD);

  logic [3:0]   w_phase;
  sched_state_e r_state, w_state_next;
  logic [1:0]   r_gnt, w_gnt_next;
  logic [1:0]   r_ack, w_ack_next;
  logic         r_vma, w_vma_next;
  logic         r_win, w_win_next;
  logic         r_last, w_last_next;
  logic         w_pick;

  mc6800_eclk_gen #(
    .E_PERIOD    (E_PERIOD),
    .E_HIGH_START(E_HIGH_START)
  ) u_eclk_gen (
    .i_clk  (MB_CLK),
    .i_rst_n(RESET),
    .o_phase(w_phase),
    .o_e_clk(MB_E_CLK)
  );

  // On a tie the requester not served last wins; otherwise the sole requester.
  always_comb begin
    w_pick = (REQ == 2'b11) ? ~r_last : REQ[REQ_POLL];
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_ack_next   = 2'b00;
    w_vma_next   = r_vma;
    w_win_next   = r_win;
    w_last_next  = r_last;
    unique case (r_state)
      StIdle: begin
        if (|REQ) begin
          w_win_next         = w_pick;
          w_gnt_next         = 2'b00;
          w_gnt_next[w_pick] = 1'b1;
          w_state_next       = StArm;
        end
      end
      StArm: begin
        // A withdrawn request is abandoned before VMA ever asserts.
        if (!REQ[r_win]) begin
          w_gnt_next   = 2'b00;
          w_state_next = StIdle;
        end else if (w_phase == LP_VMA_ARM) begin
          w_vma_next   = 1'b0;
          w_state_next = StActive;
        end
      end
      StActive: begin
        if (w_phase == LP_ACK) begin
          w_ack_next[r_win] = 1'b1;
          w_last_next       = r_win;
          w_state_next      = StDone;
        end
      end
      StDone: begin
        // Hold VMA to the end of the E period so it always covers E-high.
        if (w_phase == LP_LAST) begin
          w_vma_next   = 1'b1;
          w_gnt_next   = 2'b00;
          w_state_next = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge MB_CLK) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_gnt   <= 2'b00;
      r_ack   <= 2'b00;
      r_vma   <= 1'b1;
      r_win   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_ack   <= w_ack_next;
      r_vma   <= w_vma_next;
      r_win   <= w_win_next;
      r_last  <= w_last_next;
    end
  end

  assign GNT    = r_gnt;
  assign ACK    = r_ack;
  assign MB_VMA = r_vma;
  assign BUSY   = (r_state != StIdle);
  assign PHASE  = w_phase;

endmodule

// File: tb/tb_mc6800_bus_scheduler.sv
// tb_mc6800_bus_scheduler: directed self-checking bench for mc6800_bus_scheduler with default
// parameters (E period 10, E high 6..9, VMA from phase 2, ACK at phase 9).
module tb_mc6800_bus_scheduler;

  logic       MB_CLK;
  logic       RESET;
  logic [1:0] REQ;
  logic [1:0] GNT;
  logic [1:0] ACK;
  logic       MB_E_CLK;
  logic       MB_VMA;
  logic       BUSY;
  logic [3:0] PHASE;

  int n_tests;
  int n_fail;

  mc6800_bus_scheduler dut (
    .MB_CLK  (MB_CLK),
    .RESET   (RESET),
    .REQ     (REQ),
    .GNT     (GNT),
    .ACK     (ACK),
    .MB_E_CLK(MB_E_CLK),
    .MB_VMA  (MB_VMA),
    .BUSY    (BUSY),
    .PHASE   (PHASE)
  );

  initial MB_CLK = 1'b0;
  always #5 MB_CLK = ~MB_CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge MB_CLK);
    #1;
  endtask

  task automatic wait_phase(input logic [3:0] ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (PHASE == ph) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [3:0] ep;
    RESET = 1'b0;
    REQ   = 2'b00;
    repeat (3) tick();
    n_tests++;
    if ({PHASE, MB_E_CLK, MB_VMA, GNT, ACK, BUSY} !== {4'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: ph=%0d e=%b vma=%b gnt=%b ack=%b busy=%b, want 0 0 1 00 00 0",
               PHASE, MB_E_CLK, MB_VMA, GNT, ACK, BUSY);
    end
    RESET = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ep = 4'(k % 10);
      n_tests++;
      if ({PHASE, MB_E_CLK, MB_VMA, GNT, ACK, BUSY} !==
          {ep, (ep >= 4'd6), 1'b1, 2'b00, 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_eclk k=%0d: ph=%0d e=%b vma=%b gnt=%b ack=%b busy=%b, want ph=%0d e=%b",
                 k, PHASE, MB_E_CLK, MB_VMA, GNT, ACK, BUSY, ep, (ep >= 4'd6));
      end
    end
  endtask

  // Request raised at phase 0: served within the same E period.
  task automatic test_single_access(input logic [1:0] r, input string name);
    bit         ok;
    logic [3:0] ep;
    logic [1:0] eg, ea;
    logic       ev, eb;
    wait_phase(4'd0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_sync: phase=%0d, want 0", name, PHASE);
    end
    REQ = r;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ep = 4'(k % 10);
      eg = (ep != 4'd0) ? r : 2'b00;
      ev = (ep >= 4'd2) ? 1'b0 : 1'b1;
      ea = (ep == 4'd9) ? r : 2'b00;
      eb = (ep != 4'd0);
      n_tests++;
      if ({PHASE, GNT, MB_VMA, ACK, BUSY} !== {ep, eg, ev, ea, eb}) begin
        n_fail++;
        $display("FAIL %s k=%0d: ph=%0d gnt=%b vma=%b ack=%b busy=%b, want %0d %b %b %b %b",
                 name, k, PHASE, GNT, MB_VMA, ACK, BUSY, ep, eg, ev, ea, eb);
      end
      if (ep == 4'd9) REQ = 2'b00;
    end
  endtask

  // Both requesting continuously; requester 0 was served last, so requester 1 goes first.
  task automatic test_back_to_back();
    bit         ok;
    logic [3:0] ep;
    logic [1:0] who, eg, ea;
    logic       ev;
    wait_phase(4'd0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_sync: phase=%0d, want 0", PHASE);
    end
    REQ = 2'b11;
    for (int k = 1; k <= 30; k++) begin
      tick();
      ep  = 4'(k % 10);
      who = (((k - 1) / 10) % 2 == 0) ? 2'b10 : 2'b01;
      eg  = (ep != 4'd0) ? who : 2'b00;
      ev  = (ep >= 4'd2) ? 1'b0 : 1'b1;
      ea  = (ep == 4'd9) ? who : 2'b00;
      n_tests++;
      if ({PHASE, GNT, MB_VMA, ACK} !== {ep, eg, ev, ea}) begin
        n_fail++;
        $display("FAIL b2b k=%0d: ph=%0d gnt=%b vma=%b ack=%b, want %0d %b %b %b",
                 k, PHASE, GNT, MB_VMA, ACK, ep, eg, ev, ea);
      end
    end
    REQ = 2'b00;
  endtask

  // Request at phase 1 misses this period's VMA slot and is served in the next.
  task automatic test_late_req();
    bit         ok;
    logic [3:0] ep;
    logic [1:0] eg, ea;
    logic       ev;
    wait_phase(4'd1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL late_sync: phase=%0d, want 1", PHASE);
    end
    REQ = 2'b10;
    for (int k = 1; k <= 19; k++) begin
      tick();
      ep = 4'((k + 1) % 10);
      eg = (k <= 18) ? 2'b10 : 2'b00;
      ev = (k >= 11 && k <= 18) ? 1'b0 : 1'b1;
      ea = (k == 18) ? 2'b10 : 2'b00;
      n_tests++;
      if ({PHASE, GNT, MB_VMA, ACK} !== {ep, eg, ev, ea}) begin
        n_fail++;
        $display("FAIL late_req k=%0d: ph=%0d gnt=%b vma=%b ack=%b, want %0d %b %b %b",
                 k, PHASE, GNT, MB_VMA, ACK, ep, eg, ev, ea);
      end
      if (k == 18) REQ = 2'b00;
    end
  endtask

  task automatic test_arm_drop();
    bit ok;
    wait_phase(4'd0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drop_sync: phase=%0d, want 0", PHASE);
    end
    REQ = 2'b01;
    tick();
    n_tests++;
    if ({GNT, BUSY, MB_VMA} !== {2'b01, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL drop_grant: gnt=%b busy=%b vma=%b, want 01 1 1", GNT, BUSY, MB_VMA);
    end
    REQ = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_tests++;
      if ({GNT, MB_VMA, ACK, BUSY} !== {2'b00, 1'b1, 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL drop_abort k=%0d: gnt=%b vma=%b ack=%b busy=%b, want 00 1 00 0",
                 k, GNT, MB_VMA, ACK, BUSY);
      end
    end
    test_single_access(2'b10, "after_drop");
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_phase(4'd0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rmid_sync: phase=%0d, want 0", PHASE);
    end
    REQ = 2'b01;
    repeat (5) tick();
    n_tests++;
    if ({PHASE, GNT, MB_VMA} !== {4'd5, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_active: ph=%0d gnt=%b vma=%b, want 5 01 0", PHASE, GNT, MB_VMA);
    end
    RESET = 1'b0;
    tick();
    n_tests++;
    if ({PHASE, MB_E_CLK, MB_VMA, GNT, ACK, BUSY} !== {4'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_abort: ph=%0d e=%b vma=%b gnt=%b ack=%b busy=%b, want 0 0 1 00 00 0",
               PHASE, MB_E_CLK, MB_VMA, GNT, ACK, BUSY);
    end
    RESET = 1'b1;
    REQ   = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_tests++;
      if ({ACK, MB_VMA, GNT} !== {2'b00, 1'b1, 2'b00}) begin
        n_fail++;
        $display("FAIL rmid_quiet k=%0d: ack=%b vma=%b gnt=%b, want 00 1 00", k, ACK, MB_VMA, GNT);
      end
    end
    // Reset restores last_served to requester 1, so requester 0 wins the tie.
    wait_phase(4'd0, ok);
    REQ = 2'b11;
    tick();
    n_tests++;
    if (GNT !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_after_reset: gnt=%b, want 01", GNT);
    end
    REQ = 2'b00;
    repeat (2) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET   = 1'b0;
    REQ     = 2'b00;
    test_reset();
    test_single_access(2'b01, "single_cpu");
    test_back_to_back();
    test_late_req();
    test_arm_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
